// File: rtl/srsc_pkg.sv
// srsc_pkg: shared widths, scheduler states and channel indices for the SRSC channel scheduler
package srsc_pkg;
  localparam int DW_DEF = 8;
  localparam int TW_DEF = 10;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;
endpackage

// File: rtl/srsc_tag_pipe.sv
// srsc_tag_pipe: LAT-deep shift register of {valid, ch} tracking products inside the shared multiplier
// Ports: clk, rst (async, active-high), clear (sync flush), push_valid/push_ch (tag entering with the
//        operands), pop_valid/pop_ch (tag aligned with mul_result)
module srsc_tag_pipe #(
  parameter int LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       push_valid,
  input  logic [1:0] push_ch,
  output logic       pop_valid,
  output logic [1:0] pop_ch
);
  logic [LAT-1:0][2:0] pipe_q, pipe_d;
  logic [LAT:0][2:0]   taps;
  // taps[0] is the incoming tag, taps[i] is stage i-1, so a one-slot shift is taps[LAT-1:0]
  assign taps = {pipe_q, push_valid, push_ch};
  assign {pop_valid, pop_ch} = pipe_q[LAT-1];
  always_comb pipe_d = clear ? '0 : taps[LAT-1:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) pipe_q <= '0;
    else pipe_q <= pipe_d;
endmodule

// File: rtl/srsc_channel_scheduler.sv
// srsc_channel_scheduler: time-multiplexes one shared SRSC multiplier across the R, G, B channels of a pixel
// Ports: clk, rst (async, active-high), clear (sync abort); in_* pixel input with in_valid/in_ready;
//        mul_a/mul_b operands to and mul_result from the shared multiplier; out_r/g/b results with
//        out_valid/out_ready; busy high whenever not IDLE
module srsc_channel_scheduler
  import srsc_pkg::*;
#(
  parameter int MUL_LATENCY = 1,
  parameter int DW = DW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_diff_r,
  input  logic [DW-1:0] in_diff_g,
  input  logic [DW-1:0] in_diff_b,
  input  logic [TW-1:0] in_inv_t,
  output logic [DW-1:0] mul_a,
  output logic [TW-1:0] mul_b,
  input  logic [DW-1:0] mul_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_r,
  output logic [DW-1:0] out_g,
  output logic [DW-1:0] out_b,
  output logic          busy
);
  state_t        state_q, state_d;
  logic [1:0]    ch_cnt_q, ch_cnt_d;
  logic [DW-1:0] diff_r_q, diff_r_d, diff_g_q, diff_g_d, diff_b_q, diff_b_d;
  logic [TW-1:0] inv_t_q, inv_t_d;
  logic [DW-1:0] out_r_q, out_r_d, out_g_q, out_g_d, out_b_q, out_b_d;
  logic          issue, pop_valid, take;
  logic [1:0]    pop_ch;
  srsc_tag_pipe #(.LAT(MUL_LATENCY)) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push_valid(issue),
    .push_ch   (ch_cnt_q),
    .pop_valid (pop_valid),
    .pop_ch    (pop_ch)
  );
  assign out_r = out_r_q;
  assign out_g = out_g_q;
  assign out_b = out_b_q;
  assign busy  = state_q != IDLE;
  always_comb begin
    state_d   = state_q;
    ch_cnt_d  = ch_cnt_q;
    diff_r_d  = diff_r_q;
    diff_g_d  = diff_g_q;
    diff_b_d  = diff_b_q;
    inv_t_d   = inv_t_q;
    issue     = state_q == ISSUE;
    out_valid = !clear && state_q == DONE;
    // DONE hands off to the next pixel in the same cycle the result is taken
    in_ready  = !clear && (state_q == IDLE || (state_q == DONE && out_ready));
    take      = in_valid && in_ready;
    mul_a     = !issue ? '0 : ch_cnt_q == CH_R ? diff_r_q : ch_cnt_q == CH_G ? diff_g_q : diff_b_q;
    mul_b     = issue ? inv_t_q : '0;
    out_r_d   = (pop_valid && pop_ch == CH_R) ? mul_result : out_r_q;
    out_g_d   = (pop_valid && pop_ch == CH_G) ? mul_result : out_g_q;
    out_b_d   = (pop_valid && pop_ch == CH_B) ? mul_result : out_b_q;
    if (take) begin
      diff_r_d = in_diff_r;
      diff_g_d = in_diff_g;
      diff_b_d = in_diff_b;
      inv_t_d  = in_inv_t;
      ch_cnt_d = CH_R;
    end
    case (state_q)
      IDLE:    state_d = take ? ISSUE : IDLE;
      ISSUE: begin
        ch_cnt_d = ch_cnt_q + 2'd1;
        state_d  = ch_cnt_q == CH_B ? DRAIN : ISSUE;
      end
      DRAIN:   state_d = (pop_valid && pop_ch == CH_B) ? DONE : DRAIN;
      default: state_d = take ? ISSUE : out_ready ? IDLE : DONE;
    endcase
    if (clear) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      ch_cnt_q <= '0;
      diff_r_q <= '0;
      diff_g_q <= '0;
      diff_b_q <= '0;
      inv_t_q  <= '0;
      out_r_q  <= '0;
      out_g_q  <= '0;
      out_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      ch_cnt_q <= ch_cnt_d;
      diff_r_q <= diff_r_d;
      diff_g_q <= diff_g_d;
      diff_b_q <= diff_b_d;
      inv_t_q  <= inv_t_d;
      out_r_q  <= out_r_d;
      out_g_q  <= out_g_d;
      out_b_q  <= out_b_d;
    end
endmodule

// File: tb/tb_srsc_channel_scheduler.sv
// tb_srsc_channel_scheduler: randomized self-checking bench with a shared-multiplier model and pixel scoreboard
module tb_srsc_channel_scheduler;
  localparam int LAT_EXP = 5;
  typedef struct {int r; int g; int b; int acc;} px_t;
  logic clk = 0, rst = 1, clear = 0, in_valid = 0, out_ready = 1;
  logic [7:0] in_r = 0, in_g = 0, in_b = 0, mul_result = 0;
  logic [9:0] in_t = 0;
  logic in_ready, out_valid, busy;
  logic [7:0] mul_a, out_r, out_g, out_b;
  logic [9:0] mul_b;
  int vectors = 0, miscompares = 0, cyc = 0, acc_cnt = 0, it = 0;
  bit exp_ov, exp_ir, rand_rdy = 0;
  px_t sbq[$];
  int iq[$];

  srsc_channel_scheduler dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_diff_r(in_r), .in_diff_g(in_g), .in_diff_b(in_b), .in_inv_t(in_t),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_g(out_g), .out_b(out_b), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int smul(input int a, input int t);
    int p;
    p = (a * t) >> 8;
    return p > 255 ? 255 : p;
  endfunction

  always @(posedge clk) mul_result <= 8'(smul(int'(mul_a), int'(mul_b)));

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Reference model: pixels in flight, their accept cycle and the operand schedule they imply
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      exp_ov = sbq.size() != 0 && cyc - sbq[0].acc >= LAT_EXP && !clear;
      exp_ir = !clear && (sbq.size() == 0 || (exp_ov && out_ready));
      chk("busy", int'(busy), int'(sbq.size() != 0));
      chk("out_valid", int'(out_valid), int'(exp_ov));
      chk("in_ready", int'(in_ready), int'(exp_ir));
      chk("mul_a", int'(mul_a), iq.size() != 0 ? iq[0] : 0);
      chk("mul_b", int'(mul_b), iq.size() != 0 ? it : 0);
      if (iq.size() != 0) void'(iq.pop_front());
      if (exp_ov) begin
        chk("out_r", int'(out_r), sbq[0].r);
        chk("out_g", int'(out_g), sbq[0].g);
        chk("out_b", int'(out_b), sbq[0].b);
      end
      if (clear) begin
        sbq.delete();
        iq.delete();
      end else begin
        if (exp_ov && out_ready) void'(sbq.pop_front());
        if (in_valid && exp_ir) begin
          sbq.push_back('{smul(int'(in_r), int'(in_t)), smul(int'(in_g), int'(in_t)),
                         smul(int'(in_b), int'(in_t)), cyc});
          iq = '{int'(in_r), int'(in_g), int'(in_b)};
          it = int'(in_t);
          acc_cnt++;
        end
      end
    end
  end

  task automatic send(input int r, input int g, input int b, input int t);
    int n;
    n = acc_cnt;
    in_valid = 1;
    in_r = 8'(r);
    in_g = 8'(g);
    in_b = 8'(b);
    in_t = 10'(t);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (acc_cnt != n) break;
    end
    #1;
    if (acc_cnt == n) chk("accept_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && sbq.size() != 0; i++) @(posedge clk);
    #1;
    if (sbq.size() != 0) chk("drain_timeout", sbq.size(), 0);
  endtask

  task automatic chk_reset();
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_mul_a", int'(mul_a), 0);
    chk("rst_mul_b", int'(mul_b), 0);
    chk("rst_out_r", int'(out_r), 0);
    chk("rst_out_g", int'(out_g), 0);
    chk("rst_out_b", int'(out_b), 0);
  endtask

  task automatic rnd_px();
    send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1023));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    chk_reset();
    @(posedge clk);
    #1 rst = 0;
    send(100, 50, 255, 'h200);
    wait_idle();
    send(17, 128, 0, 'h100);
    wait_idle();
    out_ready = 0;
    send(201, 3, 77, 'h3ff);
    repeat (15) @(posedge clk);
    #1 out_ready = 1;
    wait_idle();
    send(0, 255, 255, 'h3ff);
    send(255, 0, 1, 0);
    for (int i = 0; i < 18; i++) rnd_px();
    wait_idle();
    send(60, 70, 80, 'h155);
    @(posedge clk);
    #1;
    rst = 1;
    in_valid = 0;
    sbq.delete();
    iq.delete();
    chk_reset();
    @(posedge clk);
    #1 rst = 0;
    send(10, 20, 30, 'h180);
    wait_idle();
    send(90, 91, 92, 'h0c0);
    repeat (3) @(posedge clk);
    #1;
    clear = 1;
    in_valid = 1;
    in_r = 8'd5;
    in_g = 8'd6;
    in_b = 8'd7;
    @(posedge clk);
    #1;
    clear = 0;
    in_valid = 0;
    repeat (10) @(posedge clk);
    #1 rand_rdy = 1;
    for (int i = 0; i < 15; i++) rnd_px();
    #1 rand_rdy = 0;
    @(posedge clk);
    #1 out_ready = 1;
    wait_idle();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
